if_fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline; producer side of the IF/ID interface consumed by ID.

---
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC, instruction-memory req/ready fetch, IF/ID register,
// freeze/redirect handling and discard of stale in-flight responses.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        Valid_id
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_nextpc;
  logic [31:0] redir_pc;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect = PC_IFWrite & (JR | J | Z);
    if (JR)     target = {JrAddr[31:2], 2'b00};
    else if (J) target = {JumpAddr[31:2], 2'b00};
    else        target = {BranchAddr[31:2], 2'b00};
    pc_plus4 = pc + 32'd4;
  end

  // In DISCARD the PC still holds the address of the outstanding request,
  // so the fetch address stays stable until the stale response arrives.
  assign IMemReq  = (state == FETCH) || (state == DISCARD);
  assign IMemAddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      Instruction_id <= NOP_INSTR;
      NextPC_id      <= 32'h0;
      Valid_id       <= 1'b0;
      buf_instr      <= NOP_INSTR;
      buf_nextpc     <= 32'h0;
      redir_pc       <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= FETCH;

        FETCH: begin
          if (IMemReady) begin
            if (!PC_IFWrite) begin
              buf_instr  <= IMemRdata;
              buf_nextpc <= pc_plus4;
              state      <= HOLD;
            end else if (redirect) begin
              Instruction_id <= NOP_INSTR;
              Valid_id       <= 1'b0;
              pc             <= target;
            end else begin
              Instruction_id <= IMemRdata;
              NextPC_id      <= pc_plus4;
              Valid_id       <= 1'b1;
              pc             <= pc_plus4;
            end
          end else if (redirect) begin
            Instruction_id <= NOP_INSTR;
            Valid_id       <= 1'b0;
            redir_pc       <= target;
            state          <= DISCARD;
          end else if (PC_IFWrite) begin
            Instruction_id <= NOP_INSTR;
            Valid_id       <= 1'b0;
          end
        end

        HOLD: begin
          if (PC_IFWrite) begin
            if (redirect) begin
              Instruction_id <= NOP_INSTR;
              Valid_id       <= 1'b0;
              pc             <= target;
            end else begin
              Instruction_id <= buf_instr;
              NextPC_id      <= buf_nextpc;
              Valid_id       <= 1'b1;
              pc             <= pc_plus4;
            end
            state <= FETCH;
          end
        end

        DISCARD: begin
          if (PC_IFWrite) begin
            Instruction_id <= NOP_INSTR;
            Valid_id       <= 1'b0;
          end
          if (redirect) redir_pc <= target;
          if (IMemReady) begin
            pc    <= redirect ? target : redir_pc;
            state <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed, table-driven bench for if_fetch_stage; one vector per clock cycle plus an async-reset sequence.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_IFWrite, Z, J, JR;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRdata;
  logic [31:0] Instruction_id, NextPC_id;
  logic        Valid_id;

  int total = 0;
  int passed = 0;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .PC_IFWrite(PC_IFWrite), .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemRdata(IMemRdata),
    .Instruction_id(Instruction_id), .NextPC_id(NextPC_id), .Valid_id(Valid_id)
  );

  always #5 clk = ~clk;

  // Memory word at address a is 0x1000_0000 + word index.
  assign IMemRdata = 32'h1000_0000 + {2'b00, IMemAddr[31:2]};

  typedef struct {
    logic        wr, z, j, jr, rdy;
    logic [31:0] ba, ja, jra;
    logic        ereq;
    logic [31:0] eaddr, einstr, enpc;
    logic        ev;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, z, j, jr, rdy, input logic [31:0] ba, ja, jra,
                     input logic ereq, input logic [31:0] eaddr, einstr, enpc, input logic ev);
    vec_t v;
    v.wr = wr; v.z = z; v.j = j; v.jr = jr; v.rdy = rdy;
    v.ba = ba; v.ja = ja; v.jra = jra;
    v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.enpc = enpc; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  initial begin
    //   wr z j jr rdy  BranchAddr     JumpAddr       JrAddr          req addr           instr          npc            v
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          0, 32'h0,          32'h0,         32'h0,         0); // C0 IDLE
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h0,          32'h1000_0000, 32'h4,         1); // C1
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h4,          32'h1000_0001, 32'h8,         1);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h8,          32'h1000_0002, 32'hC,         1);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'hC,          32'h1000_0003, 32'h10,        1);
    add(0,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h10,         32'h1000_0003, 32'h10,        1); // C5 freeze -> HOLD
    add(0,0,0,0,1, 32'h0,   32'h0,   32'h0,          0, 32'h10,         32'h1000_0003, 32'h10,        1);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          0, 32'h10,         32'h1000_0004, 32'h14,        1); // C7 release
    add(1,1,0,0,1, 32'h40,  32'h0,   32'h0,          1, 32'h14,         32'h0,         32'h14,        0); // C8 branch
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h40,         32'h1000_0010, 32'h44,        1);
    add(1,0,0,1,0, 32'h0,   32'h0,   32'h80,         1, 32'h44,         32'h0,         32'h44,        0); // C10 JR, not ready
    add(1,0,0,0,0, 32'h0,   32'h0,   32'h0,          1, 32'h44,         32'h0,         32'h44,        0);
    add(1,0,0,0,0, 32'h0,   32'h0,   32'h0,          1, 32'h44,         32'h0,         32'h44,        0);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h44,         32'h0,         32'h44,        0); // C13 stale data dropped
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h80,         32'h1000_0020, 32'h84,        1);
    add(1,1,1,1,1, 32'h300, 32'h200, 32'h100,        1, 32'h84,         32'h0,         32'h84,        0); // C15 JR wins
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h100,        32'h1000_0040, 32'h104,       1);
    add(0,1,0,0,1, 32'h300, 32'h0,   32'h0,          1, 32'h104,        32'h1000_0040, 32'h104,       1); // C17 frozen redirect ignored
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          0, 32'h104,        32'h1000_0041, 32'h108,       1);
    add(1,0,0,1,1, 32'h0,   32'h0,   32'hFFFF_FFFF,  1, 32'h108,        32'h0,         32'h108,       0); // C19 low bits forced 00
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'hFFFF_FFFC,  32'h4FFF_FFFF, 32'h0,         1); // C20 wrap
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h0,          32'h1000_0000, 32'h4,         1);
    add(1,0,0,0,0, 32'h0,   32'h0,   32'h0,          1, 32'h4,          32'h0,         32'h4,         0); // C22 wait bubble
    add(0,0,0,0,0, 32'h0,   32'h0,   32'h0,          1, 32'h4,          32'h0,         32'h4,         0);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h4,          32'h1000_0001, 32'h8,         1);
    add(1,0,1,0,0, 32'h0,   32'h200, 32'h0,          1, 32'h8,          32'h0,         32'h8,         0); // C25 J -> DISCARD
    add(1,1,0,0,0, 32'h300, 32'h0,   32'h0,          1, 32'h8,          32'h0,         32'h8,         0); // C26 newer target
    add(0,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h8,          32'h0,         32'h8,         0);
    add(1,0,0,0,1, 32'h0,   32'h0,   32'h0,          1, 32'h300,        32'h1000_00C0, 32'h304,       1);
    add(1,0,0,1,0, 32'h0,   32'h0,   32'h500,        1, 32'h304,        32'h0,         32'h304,       0); // C29 -> DISCARD
    add(1,0,0,0,0, 32'h0,   32'h0,   32'h0,          1, 32'h304,        32'h0,         32'h304,       0);

    rst_n = 1'b0; PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0;
    BranchAddr = '0; JumpAddr = '0; JrAddr = '0; IMemReady = 1'b0;
    @(negedge clk); #1;
    chk("rst_req",   {31'b0, IMemReq}, 32'h0);
    chk("rst_addr",  IMemAddr, 32'h0);
    chk("rst_instr", Instruction_id, 32'h0);
    chk("rst_npc",   NextPC_id, 32'h0);
    chk("rst_valid", {31'b0, Valid_id}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      PC_IFWrite = vecs[i].wr; Z = vecs[i].z; J = vecs[i].j; JR = vecs[i].jr;
      IMemReady = vecs[i].rdy; BranchAddr = vecs[i].ba; JumpAddr = vecs[i].ja; JrAddr = vecs[i].jra;
      #1;
      chk($sformatf("v%0d_req", i),  {31'b0, IMemReq}, {31'b0, vecs[i].ereq});
      chk($sformatf("v%0d_addr", i), IMemAddr, vecs[i].eaddr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_instr", i), Instruction_id, vecs[i].einstr);
      chk($sformatf("v%0d_npc", i),   NextPC_id, vecs[i].enpc);
      chk($sformatf("v%0d_valid", i), {31'b0, Valid_id}, {31'b0, vecs[i].ev});
      $display("vec %0d: addr=0x%08h instr=0x%08h npc=0x%08h valid=%0b",
               i, vecs[i].eaddr, Instruction_id, NextPC_id, Valid_id);
    end

    // Asynchronous reset in the middle of DISCARD, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'b0, IMemReq}, 32'h0);
    chk("mid_rst_addr",  IMemAddr, 32'h0);
    chk("mid_rst_instr", Instruction_id, 32'h0);
    chk("mid_rst_npc",   NextPC_id, 32'h0);
    chk("mid_rst_valid", {31'b0, Valid_id}, 32'h0);
    $display("async reset: req=%0b addr=0x%08h valid=%0b", IMemReq, IMemAddr, Valid_id);

    @(negedge clk);
    rst_n = 1'b1; PC_IFWrite = 1'b1; Z = 1'b0; J = 1'b0; JR = 1'b0; IMemReady = 1'b1;
    #1 chk("restart_idle_req", {31'b0, IMemReq}, 32'h0);
    @(negedge clk); #1;
    chk("restart_req",  {31'b0, IMemReq}, 32'h1);
    chk("restart_addr", IMemAddr, 32'h0);
    @(posedge clk); #1;
    chk("restart_instr", Instruction_id, 32'h1000_0000);
    chk("restart_npc",   NextPC_id, 32'h4);
    chk("restart_valid", {31'b0, Valid_id}, 32'h1);
    $display("restart: instr=0x%08h npc=0x%08h valid=%0b", Instruction_id, NextPC_id, Valid_id);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
